// File: rtl/ws2812_frame_sched_pkg.sv
// ws2812_frame_sched_pkg: shared types and constants for the WS2812B frame scheduler
package ws2812_frame_sched_pkg;

    localparam int PIXEL_W          = 24;
    localparam int DEF_LED_CNT      = 10;
    localparam int DEF_RESET_CYCLES = 3000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_SEND,
        ST_LATCH
    } state_t;

    // A single pixel still needs a 1-bit index port
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_latch_timer.sv
// ws2812_latch_timer: holds the latch level for RESET_CYCLES clocks after a start pulse
module ws2812_latch_timer
    import ws2812_frame_sched_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    output logic o_latch,
    output logic o_last,
    output logic o_done
);

    localparam int CNT_W = $clog2(RESET_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_latch;
    logic             r_done;

    assign o_last  = r_latch & (r_cnt == CNT_W'(RESET_CYCLES - 1));
    assign o_latch = r_latch;
    assign o_done  = r_done;

    // Count latch cycles from zero; drop the level and pulse done on the final one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_latch <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= o_last;
            r_latch <= i_start | (r_latch & ~o_last);
            r_cnt   <= (i_start | o_last) ? '0 : r_latch ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end

endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: sequences WS2812B refreshes and arbitrates the shared pixel buffer
module ws2812_frame_sched
    import ws2812_frame_sched_pkg::*;
#(
    parameter int LED_CNT      = DEF_LED_CNT,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int IDX_W        = idx_width(LED_CNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_req,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic               wr_gnt,
    input  logic               commit,
    output logic               mem_en,
    output logic               mem_we,
    output logic [IDX_W-1:0]   mem_addr,
    output logic [PIXEL_W-1:0] mem_wdata,
    input  logic [PIXEL_W-1:0] mem_rdata,
    output logic               px_valid,
    output logic [PIXEL_W-1:0] px_data,
    input  logic               px_ready,
    output logic               latch,
    output logic               busy,
    output logic               frame_done
);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_pending;
    logic               r_px_valid;
    logic [PIXEL_W-1:0] r_px_data;
    logic               w_hs;
    logic               w_last_px;
    logic               w_rd;
    logic               w_wr;
    logic               w_in_range;
    logic               w_start;
    logic               w_tmr_last;

    assign w_hs       = r_px_valid & px_ready;
    assign w_last_px  = r_idx == IDX_W'(LED_CNT - 1);
    assign w_rd       = r_state == ST_FETCH;
    assign w_in_range = {1'b0, wr_idx} < (IDX_W + 1)'(LED_CNT);
    assign wr_gnt     = wr_req & ~w_rd;
    assign w_wr       = wr_gnt & w_in_range;
    assign mem_en     = w_rd | w_wr;
    assign mem_we     = w_wr;
    assign mem_addr   = w_rd ? r_idx : wr_idx;
    assign mem_wdata  = wr_data;
    assign px_valid   = r_px_valid;
    assign px_data    = r_px_data;
    assign busy       = r_state != ST_IDLE;

    // Next state and pixel index; reads own the buffer port during FETCH
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit) begin
                    w_next     = ST_FETCH;
                    w_idx_next = '0;
                end
            end
            ST_FETCH: w_next = ST_CAPT;
            ST_CAPT:  w_next = ST_SEND;
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last_px) begin
                        w_next  = ST_LATCH;
                        w_start = 1'b1;
                    end else begin
                        w_next     = ST_FETCH;
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (w_tmr_last) begin
                    w_next     = (r_pending | commit) ? ST_FETCH : ST_IDLE;
                    w_idx_next = '0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, index, collapsed pending commit and the registered pixel word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_px_valid <= 1'b0;
            r_px_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_idx_next;
            r_pending  <= (r_state == ST_LATCH && w_tmr_last) ? 1'b0 : (busy & commit) ? 1'b1 : r_pending;
            r_px_valid <= (r_state == ST_CAPT) ? 1'b1 : w_hs ? 1'b0 : r_px_valid;
            r_px_data  <= (r_state == ST_CAPT) ? mem_rdata : r_px_data;
        end
    end

    ws2812_latch_timer #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_start),
        .o_latch(latch),
        .o_last (w_tmr_last),
        .o_done (frame_done)
    );

endmodule
